// File: rtl/multi_prio_enc_if.sv
// Request/beat bus for multi_prio_enc: a vector goes in, one index per set bit comes out.
interface multi_prio_enc_if #(
  parameter int WIDTH = 8
);
  localparam int IW = $clog2(WIDTH);

  logic [WIDTH-1:0] d;
  logic             in_valid;
  logic             in_ready;
  logic             flush;
  logic [IW-1:0]    q;
  logic             v;
  logic             last;
  logic [IW:0]      rem;
  logic             out_valid;
  logic             out_ready;

  modport slave (
    input  d, in_valid, flush, out_ready,
    output in_ready, q, v, last, rem, out_valid
  );

  modport master (
    output d, in_valid, flush, out_ready,
    input  in_ready, q, v, last, rem, out_valid
  );
endinterface

// File: rtl/multi_prio_enc.sv
// Multi-beat priority encoder: captures a request vector and emits the index of each
// set bit in priority order, one per output handshake.
module multi_prio_enc #(
  parameter int WIDTH     = 8,
  parameter int LSB_FIRST = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  multi_prio_enc_if.slave     bus
);
  localparam int IW = $clog2(WIDTH);

  if (WIDTH < 2) begin : g_width_chk
    $error("multi_prio_enc: WIDTH must be at least 2");
  end

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  logic [WIDTH-1:0] pend;
  logic [IW-1:0]    q_r;
  logic             v_r;
  logic             last_r;
  logic [IW:0]      rem_r;

  function automatic logic [IW-1:0] first_idx(input logic [WIDTH-1:0] p);
    logic [IW-1:0] idx;
    idx = '0;
    if (LSB_FIRST != 0) begin
      for (int i = WIDTH - 1; i >= 0; i--)
        if (p[i]) idx = IW'(i);
    end else begin
      for (int i = 0; i < WIDTH; i++)
        if (p[i]) idx = IW'(i);
    end
    return idx;
  endfunction

  function automatic logic [IW:0] pop_count(input logic [WIDTH-1:0] p);
    logic [IW:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++)
      c = c + (IW+1)'(p[i]);
    return c;
  endfunction

  logic             in_hs;
  logic             out_hs;
  logic             busy_nxt;
  logic [WIDTH-1:0] clr_mask;
  logic [WIDTH-1:0] pend_nxt;
  logic [IW:0]      cnt_nxt;

  assign bus.out_valid = (state == BUSY);
  assign bus.in_ready  = (state == IDLE) |
                         (bus.out_valid & bus.out_ready & last_r & ~bus.flush);
  assign bus.q         = q_r;
  assign bus.v         = v_r;
  assign bus.last      = last_r;
  assign bus.rem       = rem_r;

  assign in_hs    = bus.in_valid & bus.in_ready;
  assign out_hs   = bus.out_valid & bus.out_ready;
  // An all-zero beat (v=0) has no bit to clear.
  assign clr_mask = v_r ? ({{(WIDTH-1){1'b0}}, 1'b1} << q_r) : '0;
  assign busy_nxt = ~bus.flush & (in_hs | ((state == BUSY) & ~(out_hs & last_r)));

  always_comb begin
    pend_nxt = pend;
    if (bus.flush) begin
      pend_nxt = '0;
    end else begin
      if (out_hs) pend_nxt = pend & ~clr_mask;
      if (in_hs)  pend_nxt = bus.d;
    end
  end

  assign cnt_nxt = pop_count(pend_nxt);

  // Beat outputs are registered from the next pending vector so they are valid
  // in the cycle right after the handshake that produced them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      pend   <= '0;
      q_r    <= '0;
      v_r    <= 1'b0;
      last_r <= 1'b0;
      rem_r  <= '0;
    end else begin
      pend <= busy_nxt ? pend_nxt : '0;
      if (busy_nxt) begin
        state  <= BUSY;
        q_r    <= first_idx(pend_nxt);
        v_r    <= |pend_nxt;
        last_r <= (cnt_nxt <= (IW+1)'(1));
        rem_r  <= cnt_nxt;
      end else begin
        state  <= IDLE;
        q_r    <= '0;
        v_r    <= 1'b0;
        last_r <= 1'b0;
        rem_r  <= '0;
      end
    end
  end
endmodule
